mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 116 +++++++++++
 tb/tb_mem_access_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage data memory access controller: sequences direct and pointer-indirect
// loads/stores against a variable-latency data memory and stalls the pipeline.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        op_load,
  input  logic        op_store,
  input  logic        op_byte,
  input  logic        op_indirect,
  input  logic [15:0] addr_in,
  input  logic [15:0] store_data_in,
  output logic [15:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_byte_enable,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_resp,
  output logic [15:0] load_data_out,
  output logic        advance,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, IND, ACC, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] ptr, ptr_nxt;
  logic [15:0] ld_nxt;
  logic        is_mem, is_load, is_store;
  logic [15:0] target;
  logic [7:0]  rbyte;

  // A load+store encoding resolves to a load.
  assign is_mem   = op_load | op_store;
  assign is_load  = op_load;
  assign is_store = op_store & ~op_load;
  assign target   = op_indirect ? ptr : addr_in;
  assign rbyte    = target[0] ? mem_rdata[15:8] : mem_rdata[7:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      ptr           <= '0;
      load_data_out <= '0;
    end else begin
      state         <= state_nxt;
      ptr           <= ptr_nxt;
      load_data_out <= ld_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    ptr_nxt         = ptr;
    ld_nxt          = load_data_out;
    mem_address     = '0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = '0;
    mem_wdata       = '0;
    advance         = 1'b0;
    busy            = (state != IDLE);
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (!is_mem)          advance   = 1'b1;
          else if (op_indirect) state_nxt = IND;
          else                  state_nxt = ACC;
        end
      end
      IND: begin
        mem_read        = 1'b1;
        mem_address     = {addr_in[15:1], 1'b0};
        mem_byte_enable = 2'b11;
        if (mem_resp) begin
          ptr_nxt   = mem_rdata;
          state_nxt = ACC;
        end
      end
      ACC: begin
        mem_read  = is_load;
        mem_write = is_store;
        if (op_byte) begin
          mem_address     = target;
          mem_byte_enable = target[0] ? 2'b10 : 2'b01;
          mem_wdata       = {store_data_in[7:0], store_data_in[7:0]};
        end else begin
          mem_address     = {target[15:1], 1'b0};
          mem_byte_enable = 2'b11;
          mem_wdata       = store_data_in;
        end
        if (mem_resp) begin
          state_nxt = DONE;
          if (is_load) ld_nxt = op_byte ? {8'h00, rbyte} : mem_rdata;
        end
      end
      DONE: begin
        advance   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Hold the memory interface quiet for the whole reset window, not just after the edge.
    if (!reset_n) begin
      mem_address     = '0;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_byte_enable = '0;
      mem_wdata       = '0;
      advance         = 1'b0;
      busy            = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: hand-computed vectors checked with immediate assertions.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset_n, req_valid, op_load, op_store, op_byte, op_indirect;
  logic [15:0] addr_in, store_data_in, mem_rdata;
  logic        mem_resp;
  logic [15:0] mem_address, mem_wdata, load_data_out;
  logic        mem_read, mem_write, advance, busy;
  logic [1:0]  mem_byte_enable;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .op_load(op_load),
    .op_store(op_store), .op_byte(op_byte), .op_indirect(op_indirect),
    .addr_in(addr_in), .store_data_in(store_data_in), .mem_address(mem_address),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .load_data_out(load_data_out), .advance(advance), .busy(busy)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic req(input logic ld, input logic st, input logic by, input logic ind,
                     input logic [15:0] a, input logic [15:0] d);
    req_valid = 1'b1; op_load = ld; op_store = st; op_byte = by; op_indirect = ind;
    addr_in = a; store_data_in = d;
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; op_load = 1'b0; op_store = 1'b0; op_byte = 1'b0;
    op_indirect = 1'b0; addr_in = '0; store_data_in = '0; mem_rdata = '0; mem_resp = 1'b0;

    // reset state
    step(); step(); smp();
    chk("rst_addr", mem_address, 16'h0);
    chk("rst_rd_wr", {14'h0, mem_read, mem_write}, 16'h0);
    chk("rst_be_wdata", {mem_byte_enable, 14'h0} | mem_wdata, 16'h0);
    chk("rst_adv_busy", {14'h0, advance, busy}, 16'h0);
    chk("rst_ld", load_data_out, 16'h0);
    reset_n = 1'b1;

    // non-memory op advances combinationally
    step(); req(1'b0, 1'b0, 1'b0, 1'b0, 16'h1111, 16'h0); smp();
    chk("nomem_adv", {15'h0, advance}, 16'h1);
    chk("nomem_rdwr_busy", {13'h0, mem_read, mem_write, busy}, 16'h0);

    // LDR 0x1234, two wait cycles
    step(); req(1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0); smp();
    chk("ldr_idle_adv", {15'h0, advance}, 16'h0);
    step(); smp();
    chk("ldr_c1_rd", {14'h0, mem_read, mem_write}, 16'h2);
    chk("ldr_c1_addr", mem_address, 16'h1234);
    chk("ldr_c1_be_busy", {13'h0, mem_byte_enable, busy}, 16'h7);
    step(); smp();
    chk("ldr_c2_rd_adv", {14'h0, mem_read, advance}, 16'h2);
    step(); mem_resp = 1'b1; mem_rdata = 16'hBEEF; smp();
    chk("ldr_c3_rd", {15'h0, mem_read}, 16'h1);
    chk("ldr_c3_addr", mem_address, 16'h1234);
    step(); mem_resp = 1'b0; mem_rdata = 16'h0; smp();
    chk("ldr_done_adv", {14'h0, advance, mem_read}, 16'h2);
    chk("ldr_data", load_data_out, 16'hBEEF);
    req_valid = 1'b0;
    step(); smp();
    chk("ldr_idle_after", {14'h0, advance, busy}, 16'h0);

    // LDB odd address, zero-wait memory
    req(1'b1, 1'b0, 1'b1, 1'b0, 16'h2001, 16'h0);
    step(); mem_resp = 1'b1; mem_rdata = 16'hA55A; smp();
    chk("ldb1_addr", mem_address, 16'h2001);
    chk("ldb1_be", {14'h0, mem_byte_enable}, 16'h2);
    step(); mem_resp = 1'b0; smp();
    chk("ldb1_data", load_data_out, 16'h00A5);
    chk("ldb1_adv", {15'h0, advance}, 16'h1);
    req_valid = 1'b0; step();

    // LDB even address
    req(1'b1, 1'b0, 1'b1, 1'b0, 16'h2000, 16'h0);
    step(); mem_resp = 1'b1; smp();
    chk("ldb0_be", {14'h0, mem_byte_enable}, 16'h1);
    step(); mem_resp = 1'b0; smp();
    chk("ldb0_data", load_data_out, 16'h005A);
    req_valid = 1'b0; step();

    // STB 0x3000
    req(1'b0, 1'b1, 1'b1, 1'b0, 16'h3000, 16'h12CD);
    step(); mem_resp = 1'b1; mem_rdata = 16'hFFFF; smp();
    chk("stb_rdwr", {14'h0, mem_read, mem_write}, 16'h1);
    chk("stb_be", {14'h0, mem_byte_enable}, 16'h1);
    chk("stb_wdata", mem_wdata, 16'hCDCD);
    step(); mem_resp = 1'b0; smp();
    chk("stb_ld_keep", load_data_out, 16'h005A);
    chk("stb_adv", {15'h0, advance}, 16'h1);
    req_valid = 1'b0; step();

    // STR to odd address: bit0 forced low, full word
    req(1'b0, 1'b1, 1'b0, 1'b0, 16'h3003, 16'hBEAD);
    step(); mem_resp = 1'b1; smp();
    chk("str_addr", mem_address, 16'h3002);
    chk("str_be", {14'h0, mem_byte_enable}, 16'h3);
    chk("str_wdata", mem_wdata, 16'hBEAD);
    step(); mem_resp = 1'b0; smp();
    chk("str_ld_keep", load_data_out, 16'h005A);
    req_valid = 1'b0; step();

    // LDI 0x4000 -> pointer 0x5002 -> 0x7777
    req(1'b1, 1'b0, 1'b0, 1'b1, 16'h4000, 16'h0);
    step(); smp();
    chk("ldi_ind_rd", {14'h0, mem_read, mem_write}, 16'h2);
    chk("ldi_ind_addr", mem_address, 16'h4000);
    step(); mem_resp = 1'b1; mem_rdata = 16'h5002; smp();
    chk("ldi_ind_adv", {15'h0, advance}, 16'h0);
    step(); mem_resp = 1'b0; mem_rdata = 16'h0; smp();
    chk("ldi_acc_addr", mem_address, 16'h5002);
    chk("ldi_acc_rd_adv", {14'h0, mem_read, advance}, 16'h2);
    step(); mem_resp = 1'b1; mem_rdata = 16'h7777; smp();
    chk("ldi_acc2_adv", {15'h0, advance}, 16'h0);
    step(); mem_resp = 1'b0; smp();
    chk("ldi_data", load_data_out, 16'h7777);
    chk("ldi_adv", {15'h0, advance}, 16'h1);
    req_valid = 1'b0;
    step(); smp();
    chk("ldi_single_adv", {14'h0, advance, busy}, 16'h0);

    // load+store encoding acts as load
    req(1'b1, 1'b1, 1'b0, 1'b0, 16'h6000, 16'h2222);
    step(); mem_resp = 1'b1; mem_rdata = 16'h1111; smp();
    chk("ldst_rdwr", {14'h0, mem_read, mem_write}, 16'h2);
    step(); mem_resp = 1'b0; smp();
    chk("ldst_data", load_data_out, 16'h1111);
    req_valid = 1'b0; step();

    // reset during STR access, late resp ignored
    req(1'b0, 1'b1, 1'b0, 1'b0, 16'h7000, 16'h5555);
    step(); smp();
    chk("rstacc_wr", {14'h0, mem_read, mem_write}, 16'h1);
    reset_n = 1'b0; req_valid = 1'b0;
    step(); reset_n = 1'b1; mem_resp = 1'b1; mem_rdata = 16'h9999; smp();
    chk("rstacc_wr_drop", {13'h0, mem_write, advance, busy}, 16'h0);
    chk("rstacc_addr", mem_address, 16'h0);
    chk("rstacc_ld", load_data_out, 16'h0);
    step(); mem_resp = 1'b0; smp();
    chk("rstacc_late", {13'h0, mem_read, advance, busy}, 16'h0);
    chk("rstacc_ld_hold", load_data_out, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
